// File: rtl/toff_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | toff_pkg: shared types and widths for the reversible-gate sequencer.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package toff_pkg;

    localparam int DEF_NBITS = 8;
    localparam int DEF_DEPTH = 16;
    localparam int DEF_IDXW  = $clog2(DEF_NBITS);
    localparam int DEF_AW    = $clog2(DEF_DEPTH);
    localparam int INSTR_W   = 2 + 3 * DEF_IDXW;

    typedef enum logic [1:0] {
        OP_NOP  = 2'b00,
        OP_NOT  = 2'b01,
        OP_CNOT = 2'b10,
        OP_TOFF = 2'b11
    } op_t;

    typedef struct packed {
        op_t                 op;
        logic [DEF_IDXW-1:0] a;
        logic [DEF_IDXW-1:0] b;
        logic [DEF_IDXW-1:0] t;
    } instr_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic logic toff_gate(input logic a, input logic b, input logic c);
        return c ^ (a & b);
    endfunction

endpackage
`default_nettype wire

// File: rtl/toff_apply.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | toff_apply: applies one reversible instruction to the working register.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module toff_apply
    import toff_pkg::*;
#(
    parameter int NBITS = DEF_NBITS
)(
    input  instr_t           instr,
    input  logic [NBITS-1:0] w_in,
    output logic [NBITS-1:0] w_out,
    output logic             illegal
);

    // Work on a register padded to the full index range so any encodable
    // index can be read safely; out-of-range lines are flagged illegal.
    localparam int LINES = 2 ** DEF_IDXW;

    logic [LINES-1:0] line_ok;
    logic [LINES-1:0] ext;
    logic [LINES-1:0] res;
    logic             two_operand;

    always_comb begin
        line_ok = '0;
        for (int i = 0; i < NBITS; i++) begin
            line_ok[i] = 1'b1;
        end
        ext         = LINES'(w_in);
        two_operand = (instr.op == OP_CNOT) || (instr.op == OP_TOFF);
        illegal     = !line_ok[instr.a] || !line_ok[instr.b] || !line_ok[instr.t] ||
                      (two_operand && ((instr.t == instr.a) || (instr.t == instr.b)));

        res = ext;
        if (!illegal) begin
            case (instr.op)
                OP_NOT:  res[instr.t] = ~ext[instr.t];
                OP_CNOT: res[instr.t] = ext[instr.t] ^ ext[instr.a];
                OP_TOFF: res[instr.t] = toff_gate(ext[instr.a], ext[instr.b], ext[instr.t]);
                default: res = ext;
            endcase
        end
        w_out = res[NBITS-1:0];
    end

endmodule
`default_nettype wire

// File: rtl/toff_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | toff_seq_ctrl: runs a stored reversible-gate program forward or reversed.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module toff_seq_ctrl
    import toff_pkg::*;
#(
    parameter int NBITS = DEF_NBITS,
    parameter int DEPTH = DEF_DEPTH,
    parameter int IDXW  = $clog2(NBITS),
    parameter int AW    = $clog2(DEPTH)
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  prog_we,
    input  logic [AW-1:0]         prog_addr,
    input  logic [2+3*IDXW-1:0]   prog_data,
    input  logic [AW:0]           prog_len,
    input  logic                  start,
    input  logic                  reverse,
    input  logic [NBITS-1:0]      data_in,
    output logic                  ready,
    output logic                  busy,
    output logic                  done,
    output logic [NBITS-1:0]      data_out,
    output logic                  err
);

    localparam logic [AW:0] LEN_ONE = (AW+1)'(1);
    localparam logic [AW:0] LEN_MAX = (AW+1)'(DEPTH);

    state_t           state;
    state_t           state_nxt;
    instr_t           mem [DEPTH];
    logic [NBITS-1:0] work;
    logic [NBITS-1:0] next_w;
    logic [AW:0]      len;
    logic [AW:0]      cnt;
    logic [AW:0]      len_clamp;
    logic [AW:0]      len_m1;
    logic [AW-1:0]    pc;
    logic             rev;
    logic             illegal;
    logic             last_step;
    logic             accept;

    assign len_clamp = (prog_len > LEN_MAX) ? LEN_MAX : prog_len;
    assign len_m1    = len_clamp - LEN_ONE;
    assign last_step = (cnt == (len - LEN_ONE));
    assign accept    = (state == S_IDLE) && start;

    toff_apply #(
        .NBITS (NBITS)
    ) u_apply (
        .instr   (mem[pc]),
        .w_in    (work),
        .w_out   (next_w),
        .illegal (illegal)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                ready = 1'b1;
                if (start) begin
                    state_nxt = (len_clamp == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (last_step) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Writes are only honoured in IDLE, so a running program never changes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if ((state == S_IDLE) && prog_we) begin
            mem[prog_addr] <= instr_t'(prog_data);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            work     <= '0;
            len      <= '0;
            cnt      <= '0;
            pc       <= '0;
            rev      <= 1'b0;
            err      <= 1'b0;
            data_out <= '0;
        end else begin
            if (accept) begin
                work <= data_in;
                len  <= len_clamp;
                cnt  <= '0;
                rev  <= reverse;
                err  <= 1'b0;
                pc   <= reverse ? len_m1[AW-1:0] : '0;
                if (len_clamp == '0) begin
                    data_out <= data_in;
                end
            end else if (state == S_RUN) begin
                work <= next_w;
                cnt  <= cnt + LEN_ONE;
                err  <= err | illegal;
                // The result is captured as the last gate lands so it is
                // already valid in the cycle that done is high.
                if (last_step) begin
                    data_out <= next_w;
                end else begin
                    pc <= rev ? (pc - AW'(1)) : (pc + AW'(1));
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_toff_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_toff_seq_ctrl: scoreboard bench with a gate-level program model.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_toff_seq_ctrl;

    localparam int NB  = 8;
    localparam int DP  = 16;
    localparam int INW = 11;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           prog_we = 1'b0;
    logic [3:0]     prog_addr = '0;
    logic [INW-1:0] prog_data = '0;
    logic [4:0]     prog_len = '0;
    logic           start = 1'b0;
    logic           reverse = 1'b0;
    logic [NB-1:0]  data_in = '0;
    logic           ready;
    logic           busy;
    logic           done;
    logic [NB-1:0]  data_out;
    logic           err;

    toff_seq_ctrl #(.NBITS(NB), .DEPTH(DP)) dut (
        .clk       (clk),
        .rst       (rst),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .prog_len  (prog_len),
        .start     (start),
        .reverse   (reverse),
        .data_in   (data_in),
        .ready     (ready),
        .busy      (busy),
        .done      (done),
        .data_out  (data_out),
        .err       (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] d;
        logic       e;
        int         c;
    } exp_t;

    exp_t           sb[$];
    logic [INW-1:0] mmem [DP];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [INW-1:0] mk(input int op, input int a, input int b, input int t);
        return {op[1:0], a[2:0], b[2:0], t[2:0]};
    endfunction

    // Program semantics: visit slots in order (or reversed), flip the target
    // line when the gate condition holds, skip and flag malformed gates.
    function automatic exp_t model(input int l, input bit rv, input logic [7:0] din);
        exp_t r;
        int n;
        n   = (l > DP) ? DP : l;
        r.d = din;
        r.e = 1'b0;
        r.c = 0;
        for (int k = 0; k < n; k++) begin
            logic [INW-1:0] ins;
            int op, a, b, t;
            bit bad;
            ins = mmem[rv ? (n - 1 - k) : k];
            op  = int'(ins[10:9]);
            a   = int'(ins[8:6]);
            b   = int'(ins[5:3]);
            t   = int'(ins[2:0]);
            bad = (a >= NB) || (b >= NB) || (t >= NB) || (op >= 2 && (t == a || t == b));
            if (bad) r.e = 1'b1;
            else if (op == 1) r.d = r.d ^ 8'(1 << t);
            else if (op == 2 && r.d[a]) r.d = r.d ^ 8'(1 << t);
            else if (op == 3 && r.d[a] && r.d[b]) r.d = r.d ^ 8'(1 << t);
        end
        return r;
    endfunction

    always @(negedge clk) begin : monitor
        exp_t x;
        if (!rst && done) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=1 required=0 (t=%0t)", $time);
            end else begin
                x = sb.pop_front();
                check("done_data", 32'(data_out), 32'(x.d));
                check("done_err", 32'(err), 32'(x.e));
                check("done_cycle", cyc, x.c);
            end
        end
    end

    task automatic drain();
        #1;
        for (int i = 0; i < 60; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
            #1;
        end
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL done_timeout actual=%0d_pending required=0", sb.size());
            sb.delete();
        end
    endtask

    task automatic write_slot(input int addr, input logic [INW-1:0] ins);
        prog_we   = 1'b1;
        prog_addr = addr[3:0];
        prog_data = ins;
        @(negedge clk);
        prog_we   = 1'b0;
        mmem[addr] = ins;
    endtask

    // Optional same-edge program write; optional directed expectation.
    task automatic run(input int l, input bit rv, input logic [7:0] din,
                       input bit wr, input int waddr, input logic [INW-1:0] wins,
                       input bit use_exp, input logic [7:0] xd, input bit xe);
        exp_t x;
        int n;
        n = (l > DP) ? DP : l;
        if (wr) begin
            prog_we   = 1'b1;
            prog_addr = waddr[3:0];
            prog_data = wins;
            mmem[waddr] = wins;
        end
        x = model(l, rv, din);
        if (use_exp) begin
            x.d = xd;
            x.e = xe;
        end
        x.c = cyc + 1 + n;
        sb.push_back(x);
        start    = 1'b1;
        reverse  = rv;
        prog_len = l[4:0];
        data_in  = din;
        @(negedge clk);
        start   = 1'b0;
        prog_we = 1'b0;
        check("err_cleared_on_start", 32'(err), 32'(0));
        check("busy_after_start", 32'(busy), 32'(n != 0));
        drain();
        @(negedge clk);
        check("ready_idle", 32'(ready), 32'(1));
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [7:0] d0;
        for (int i = 0; i < DP; i++) mmem[i] = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(ready), 32'(1));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_err", 32'(err), 32'(0));
        check("rst_data_out", 32'(data_out), 32'(0));
        rst = 1'b0;
        @(negedge clk);

        // Basic Toffoli
        write_slot(0, mk(3, 0, 1, 2));
        run(1, 0, 8'h03, 0, 0, '0, 1, 8'h07, 0);

        // Reversibility
        write_slot(0, mk(1, 0, 0, 7));
        write_slot(1, mk(2, 0, 0, 3));
        write_slot(2, mk(3, 3, 7, 5));
        run(3, 0, 8'h01, 0, 0, '0, 1, 8'hA9, 0);
        run(3, 1, 8'hA9, 0, 0, '0, 1, 8'h01, 0);

        // Empty program
        run(0, 0, 8'h5A, 0, 0, '0, 1, 8'h5A, 0);

        // Illegal instruction, then a clean run clears err
        write_slot(0, mk(3, 2, 4, 2));
        run(1, 0, 8'h14, 0, 0, '0, 1, 8'h14, 1);
        write_slot(0, mk(1, 0, 0, 4));
        run(1, 0, 8'h14, 0, 0, '0, 1, 8'h04, 0);

        // Busy protection
        write_slot(0, mk(2, 1, 1, 6));
        for (int i = 1; i < 5; i++) write_slot(i, mk(3, i, i + 1, 0));
        begin : busy_prot
            exp_t x;
            x   = model(5, 0, 8'h00);
            x.c = cyc + 1 + 5;
            sb.push_back(x);
            start = 1'b1; reverse = 1'b0; prog_len = 5'd5; data_in = 8'h00;
            @(negedge clk);
            start = 1'b0;
            @(negedge clk);
            start = 1'b1; prog_we = 1'b1; prog_addr = 4'd0;
            prog_data = mk(1, 0, 0, 0); data_in = 8'hFF;
            check("busy_mid_run", 32'(busy), 32'(1));
            @(negedge clk);
            start = 1'b0; prog_we = 1'b0;
            drain();
            repeat (6) @(negedge clk);
        end
        run(5, 0, 8'h00, 0, 0, '0, 0, '0, 0);

        // Reset mid-run
        for (int i = 0; i < 5; i++) write_slot(i, mk(1, 0, 0, i));
        start = 1'b1; reverse = 1'b0; prog_len = 5'd5; data_in = 8'h33;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_ready", 32'(ready), 32'(1));
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < DP; i++) mmem[i] = '0;
        repeat (8) @(negedge clk);
        check("midrst_data_out", 32'(data_out), 32'(0));
        check("midrst_done", 32'(done), 32'(0));
        check("midrst_err", 32'(err), 32'(0));
        run(5, 0, 8'h33, 0, 0, '0, 1, 8'h33, 0);
        for (int i = 0; i < 5; i++) write_slot(i, mk(1, 0, 0, i));
        run(5, 0, 8'h33, 0, 0, '0, 1, 8'h2C, 0);

        // Randomized programs, lengths (including clamp) and directions
        for (int it = 0; it < 40; it++) begin
            int nw;
            nw = $urandom_range(0, 4);
            for (int w = 0; w < nw; w++) begin
                write_slot($urandom_range(0, DP - 1),
                           mk($urandom_range(0, 3), $urandom_range(0, 7),
                              $urandom_range(0, 7), $urandom_range(0, 7)));
            end
            d0 = 8'($urandom);
            run($urandom_range(0, 31), 1'($urandom_range(0, 1)), d0,
                ($urandom_range(0, 3) == 0), $urandom_range(0, 3),
                mk($urandom_range(0, 3), $urandom_range(0, 7),
                   $urandom_range(0, 7), $urandom_range(0, 7)),
                0, '0, 0);
        end

        drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/toff_seq_ctrl.md
Name: toff_seq_ctrl

Overview:
- Sequencer that runs a stored program of reversible gate operations (NOT / CNOT / Toffoli) on an NBITS working register, one gate per clock.
- Sits above the Toffoli datapath. It holds a small program memory, accepts an operand with a start handshake, and executes the program forward or in reverse order. Reverse order undoes the computation because every gate is self-inverse.
- Returns the result with a done pulse.

Parameters:
- NBITS, 8, working register width (number of reversible lines)
- DEPTH, 16, program memory slots
- IDXW, $clog2(NBITS), line-index width
- AW, $clog2(DEPTH), program address width

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- prog_we  in  1  program write strobe
- prog_addr  in  AW  program write address
- prog_data  in  2+3*IDXW  instruction {op[1:0], ctrl_a, ctrl_b, target}
- prog_len  in  AW+1  number of instructions to run (0..DEPTH), sampled at start
- start  in  1  request a run; accepted only while ready=1
- reverse  in  1  sampled at start; 1 = run from slot prog_len-1 down to slot 0
- data_in  in  NBITS  initial register value, sampled at start
- ready  out  1  high in IDLE
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse when data_out is updated
- data_out  out  NBITS  result; holds until the next done
- err  out  1  sticky illegal-instruction flag; cleared on the next accepted start

Behaviour:
- Async reset effects:
  - state goes to IDLE; ready=1, busy=0, done=0, err=0, data_out=0.
  - Working register, pc and counter are cleared.
  - All program slots are cleared to NOP.
  - Reset asserted mid-run aborts the run; no done is produced.
- Opcodes, all applied to the working register W:
  - 00 NOP: no change.
  - 01 NOT: W[t] ^= 1.
  - 10 CNOT: W[t] ^= W[a].
  - 11 TOFF: W[t] ^= W[a] & W[b]. a==b is legal.
- Illegal instruction:
  - Applies to CNOT/TOFF with t==a or t==b, and to any instruction with an index >= NBITS.
  - It executes as NOP and sets err.
  - The run continues normally.
- States:
  - IDLE:
    - prog_we writes prog_data to slot prog_addr on this edge.
    - start=1 moves to RUN. On that edge: W<=data_in; len<=prog_len; pc<=reverse ? len-1 : 0; cnt<=0; err<=0.
    - If prog_len==0, go directly to DONE instead of RUN.
  - RUN:
    - Each cycle: W <= apply(mem[pc], W); cnt++.
    - pc moves by +1 (forward) or -1 (reverse).
    - After the instruction with cnt==len-1 executes, go to DONE.
  - DONE:
    - data_out<=W and done=1 for exactly this cycle.
    - Return to IDLE on the next edge.
- Latency: start sampled at edge 0 gives done high in cycle len+1. Example: len=3 gives done in cycle 4; len=0 gives done in cycle 1.
- Busy rules:
  - start and prog_we are ignored outside IDLE, so memory is never modified during a run.
  - start and prog_we together in IDLE: the write lands and the run starts on the same edge. The run reads the new slot contents from cycle 1 onward.
- prog_len > DEPTH is clamped to DEPTH.
- pc never wraps: the counter terminates the run before pc leaves the range 0..len-1.

Decomposition:
- Package toff_pkg holds:
  - the op_t enum (OP_NOP, OP_NOT, OP_CNOT, OP_TOFF);
  - the instr_t packed struct {op, a, b, t};
  - the state_t enum (S_IDLE, S_RUN, S_DONE);
  - the width localparams.
- Sub-module toff_apply, purely combinational:
  - inputs instr_t and NBITS W; outputs next W and an illegal flag;
  - its gate equation matches the team's Toffoli gate (c ^ (a & b)).
- The FSM, program memory and counters live in toff_seq_ctrl.

Test Plan:
1. Basic Toffoli: program slot0 = TOFF(a=0,b=1,t=2), len=1, data_in=8'h03 -> data_out=8'h07, done in cycle 2, err=0.
2. Reversibility: program [NOT t=7; CNOT a=0,t=3; TOFF a=3,b=7,t=5], forward with data_in=8'h01 -> data_out=8'hA9. Then reverse with data_in=8'hA9 -> data_out=8'h01.
3. len=0 with start, data_in=8'h5A -> done in cycle 1, data_out=8'h5A; busy never asserted.
4. Illegal instruction: TOFF(a=2,b=4,t=2), data_in=8'h14 -> data_out=8'h14, err=1. The next accepted start clears err.
5. Busy protection: start, plus prog_we to slot 0, pulsed mid-run -> no second run, memory unchanged, exactly one done pulse.
6. Reset mid-run: rst asserted in cycle 2 of a len=5 run -> no done, data_out=0, ready=1. A rerun of the program after reloading it matches the expected result.
